// File: rtl/matrix_3x3_gen_pkg.sv
// Shared widths, window row payload and helpers for the 3x3 window generator.
package matrix_3x3_gen_pkg;

    localparam int unsigned PIX_W = 8;

    // One row of the 3x3 window, p1 is the leftmost (oldest column) pixel.
    typedef struct packed {
        logic [PIX_W-1:0] p1;
        logic [PIX_W-1:0] p2;
        logic [PIX_W-1:0] p3;
    } row_t;

    // Ceil-log2, never below 1 so that a depth-1 buffer still gets an address bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Shift a window row left by one column, zero-filling columns left of the line start.
    function automatic row_t shift_row(input row_t             cur,
                                       input logic [PIX_W-1:0] new_pix,
                                       input logic             col_is_0,
                                       input logic             col_is_1);
        row_t nxt;
        nxt.p3 = new_pix;
        nxt.p2 = col_is_0 ? '0 : cur.p3;
        nxt.p1 = (col_is_0 || col_is_1) ? '0 : cur.p2;
        return nxt;
    endfunction

endpackage

// File: rtl/matrix_3x3_gen_if.sv
// Pixel-stream input and 3x3 window output bundle of the window generator.
interface matrix_3x3_gen_if;
    import matrix_3x3_gen_pkg::*;

    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic [PIX_W-1:0] per_img_y;

    logic             post_frame_vsync;
    logic             post_frame_href;
    logic             post_frame_clken;
    logic [PIX_W-1:0] matrix_p11;
    logic [PIX_W-1:0] matrix_p12;
    logic [PIX_W-1:0] matrix_p13;
    logic [PIX_W-1:0] matrix_p21;
    logic [PIX_W-1:0] matrix_p22;
    logic [PIX_W-1:0] matrix_p23;
    logic [PIX_W-1:0] matrix_p31;
    logic [PIX_W-1:0] matrix_p32;
    logic [PIX_W-1:0] matrix_p33;

    // Video source side: drives the raster stream, observes the window.
    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );

    // Window generator side.
    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );

endinterface

// File: rtl/matrix_3x3_gen_linebuf_2tap.sv
// Two cascaded line delays sharing one address: tap1 = previous line, tap2 = line before it.
module matrix_3x3_gen_linebuf_2tap
    import matrix_3x3_gen_pkg::*;
#(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned ADDR_W = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PIX_W-1:0]  i_din,
    output logic [PIX_W-1:0]  o_tap1,
    output logic [PIX_W-1:0]  o_tap2
);

    logic [PIX_W-1:0] r_mem1 [DEPTH];
    logic [PIX_W-1:0] r_mem2 [DEPTH];
    logic [PIX_W-1:0] r_tap1;
    logic [PIX_W-1:0] r_tap2;

    // Read-before-write: the old column contents come out while the line shifts down one slot.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tap1         <= r_mem1[i_addr];
            r_tap2         <= r_mem2[i_addr];
            r_mem1[i_addr] <= i_din;
            r_mem2[i_addr] <= r_mem1[i_addr];
        end
    end

    assign o_tap1 = r_tap1;
    assign o_tap2 = r_tap2;

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood window generator: line counters, line buffer, row masking,
// window shift registers and 2-cycle sync alignment.
module matrix_3x3_gen
    import matrix_3x3_gen_pkg::*;
#(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480
) (
    input  logic             clk,
    input  logic             rst,
    matrix_3x3_gen_if.slave  vif
);

    localparam int unsigned ADDR_W = clog2_min1(IMG_HDISP);
    localparam int unsigned COL_W  = ADDR_W + 1;
    // A frame shorter than two lines never needs the oldest tap.
    localparam logic [1:0]  ROW_SAT = (IMG_VDISP >= 2) ? 2'd2 : 2'(IMG_VDISP);

    logic             r_vsync_d1;
    logic             r_href_d1;
    logic [COL_W-1:0] r_col_cnt;
    logic [1:0]       r_row_cnt;

    logic             r_v_d1;
    logic [COL_W-1:0] r_col_d1;
    logic [1:0]       r_row_d1;
    logic [PIX_W-1:0] r_row3_d;

    row_t             r_win1;
    row_t             r_win2;
    row_t             r_win3;
    logic             r_post_vsync;
    logic             r_post_href;
    logic             r_post_clken;

    logic             w_vs_rise;
    logic             w_href_fall;
    logic             w_pix_v;
    logic [ADDR_W-1:0] w_addr;
    logic [PIX_W-1:0] w_tap1;
    logic [PIX_W-1:0] w_tap2;
    logic [PIX_W-1:0] w_row2_pix;
    logic [PIX_W-1:0] w_row1_pix;
    logic             w_col_is_0;
    logic             w_col_is_1;

    assign w_vs_rise   = vif.per_frame_vsync & ~r_vsync_d1;
    assign w_href_fall = r_href_d1 & ~vif.per_frame_href;
    assign w_pix_v     = vif.per_frame_clken & vif.per_frame_href &
                         (r_col_cnt < COL_W'(IMG_HDISP));
    assign w_addr      = r_col_cnt[ADDR_W-1:0];

    matrix_3x3_gen_linebuf_2tap #(
        .DEPTH  (IMG_HDISP),
        .ADDR_W (ADDR_W)
    ) u_linebuf (
        .clk     (clk),
        .i_wr_en (w_pix_v),
        .i_addr  (w_addr),
        .i_din   (vif.per_img_y),
        .o_tap1  (w_tap1),
        .o_tap2  (w_tap2)
    );

    // Sync edge history plus column/row position; a frame start overrides a coincident line end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d1 <= 1'b0;
            r_href_d1  <= 1'b0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
        end else begin
            r_vsync_d1 <= vif.per_frame_vsync;
            r_href_d1  <= vif.per_frame_href;
            if (w_vs_rise || w_href_fall) begin
                r_col_cnt <= '0;
            end else if (w_pix_v) begin
                r_col_cnt <= r_col_cnt + COL_W'(1);
            end
            if (w_vs_rise) begin
                r_row_cnt <= '0;
            end else if (w_href_fall && (r_row_cnt < ROW_SAT)) begin
                r_row_cnt <= r_row_cnt + 2'd1;
            end
        end
    end

    // Stage 1: capture the pixel and its position alongside the line-buffer read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_d1   <= 1'b0;
            r_col_d1 <= '0;
            r_row_d1 <= '0;
            r_row3_d <= '0;
        end else begin
            r_v_d1 <= w_pix_v;
            if (w_pix_v) begin
                r_col_d1 <= r_col_cnt;
                r_row_d1 <= r_row_cnt;
                r_row3_d <= vif.per_img_y;
            end
        end
    end

    // Lines that do not exist yet in this frame read as zero, hiding stale buffer contents.
    assign w_row2_pix = (r_row_d1 >= 2'd1) ? w_tap1 : '0;
    assign w_row1_pix = (r_row_d1 >= 2'd2) ? w_tap2 : '0;
    assign w_col_is_0 = (r_col_d1 == COL_W'(0));
    assign w_col_is_1 = (r_col_d1 == COL_W'(1));

    // Stage 2: shift the window and align syncs/strobe to the same 2-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win1       <= '0;
            r_win2       <= '0;
            r_win3       <= '0;
            r_post_vsync <= 1'b0;
            r_post_href  <= 1'b0;
            r_post_clken <= 1'b0;
        end else begin
            r_post_vsync <= r_vsync_d1;
            r_post_href  <= r_href_d1;
            r_post_clken <= r_v_d1;
            if (r_v_d1) begin
                r_win1 <= shift_row(r_win1, w_row1_pix, w_col_is_0, w_col_is_1);
                r_win2 <= shift_row(r_win2, w_row2_pix, w_col_is_0, w_col_is_1);
                r_win3 <= shift_row(r_win3, r_row3_d,   w_col_is_0, w_col_is_1);
            end
        end
    end

    assign vif.post_frame_vsync = r_post_vsync;
    assign vif.post_frame_href  = r_post_href;
    assign vif.post_frame_clken = r_post_clken;
    assign vif.matrix_p11       = r_win1.p1;
    assign vif.matrix_p12       = r_win1.p2;
    assign vif.matrix_p13       = r_win1.p3;
    assign vif.matrix_p21       = r_win2.p1;
    assign vif.matrix_p22       = r_win2.p2;
    assign vif.matrix_p23       = r_win2.p3;
    assign vif.matrix_p31       = r_win3.p1;
    assign vif.matrix_p32       = r_win3.p2;
    assign vif.matrix_p33       = r_win3.p3;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen with a frame-level reference model.
module tb_matrix_3x3_gen;

    localparam int HD = 4;

    logic clk;
    logic rst;

    matrix_3x3_gen_if vif ();

    matrix_3x3_gen #(
        .IMG_HDISP (HD),
        .IMG_VDISP (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [71:0] sb_q [$];

    // Reference model: image lines as seen by the buffer, plus the position in the frame.
    logic [7:0] m_cur   [HD];
    logic [7:0] m_hist1 [HD];
    logic [7:0] m_hist2 [HD];
    int         m_col  = 0;
    int         m_line = 0;

    function automatic logic [71:0] model_window(input logic [7:0] pix);
        logic [7:0] w [3][3];
        int cc;
        for (int j = 0; j < 3; j++) begin
            cc = m_col - 2 + j;
            w[0][j] = 8'h00;
            w[1][j] = 8'h00;
            w[2][j] = 8'h00;
            if (cc >= 0) begin
                w[2][j] = (j == 2) ? pix : m_cur[cc];
                if (m_line >= 1) w[1][j] = m_hist1[cc];
                if (m_line >= 2) w[0][j] = m_hist2[cc];
            end
        end
        return {w[0][0], w[0][1], w[0][2], w[1][0], w[1][1], w[1][2], w[2][0], w[2][1], w[2][2]};
    endfunction

    task automatic model_line_end();
        for (int c = 0; c < m_col; c++) begin
            m_hist2[c] = m_hist1[c];
            m_hist1[c] = m_cur[c];
        end
        m_col  = 0;
        m_line = m_line + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic [7:0] pix);
        vif.per_frame_href  = 1'b1;
        vif.per_frame_clken = 1'b1;
        vif.per_img_y       = pix;
        if (m_col < HD) begin
            sb_q.push_back(model_window(pix));
            m_cur[m_col] = pix;
            m_col = m_col + 1;
        end
        tick();
    endtask

    task automatic start_frame();
        vif.per_frame_vsync = 1'b1;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        m_line = 0;
        m_col  = 0;
        tick();
        tick();
        vif.per_frame_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int n_pix, input bit rnd, input int row, input bit gaps);
        logic [7:0] pix;
        for (int c = 0; c < n_pix; c++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                vif.per_frame_href  = 1'b1;
                vif.per_frame_clken = 1'b0;
                vif.per_img_y       = 8'($urandom);
                tick();
            end
            pix = rnd ? 8'($urandom) : 8'(8'h01 + 16 * row + c);
            drive_pixel(pix);
        end
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_y       = 8'h00;
        model_line_end();
        tick();
        if (gaps) repeat ($urandom_range(0, 2)) tick();
    endtask

    // Monitor: reset values, sync delay and window contents against the scoreboard.
    logic [71:0] mon_act;
    logic [71:0] mon_exp;
    logic        hv1 = 1'b0, hv2 = 1'b0, hh1 = 1'b0, hh2 = 1'b0;
    int          since_rst = 0;

    always @(negedge clk) begin
        mon_act = {vif.matrix_p11, vif.matrix_p12, vif.matrix_p13,
                   vif.matrix_p21, vif.matrix_p22, vif.matrix_p23,
                   vif.matrix_p31, vif.matrix_p32, vif.matrix_p33};
        if (rst) begin
            since_rst = 0;
            n_checks++;
            if ({vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, mon_act} != '0) begin
                n_fail++;
                $display("FAIL reset_zero: got sync=%b%b%b win=%h, want all zero",
                         vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, mon_act);
            end
        end else begin
            if (since_rst >= 3) begin
                n_checks += 2;
                if (vif.post_frame_vsync !== hv2) begin
                    n_fail++;
                    $display("FAIL post_vsync: got %b want %b at %0t", vif.post_frame_vsync, hv2, $time);
                end
                if (vif.post_frame_href !== hh2) begin
                    n_fail++;
                    $display("FAIL post_href: got %b want %b at %0t", vif.post_frame_href, hh2, $time);
                end
            end
            if (since_rst < 10) since_rst++;
            if (vif.post_frame_clken) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_clken: got window %h, want no strobe at %0t", mon_act, $time);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_fail++;
                        $display("FAIL window: got %h want %h at %0t", mon_act, mon_exp, $time);
                    end
                end
            end
        end
        hv2 = hv1;
        hv1 = vif.per_frame_vsync;
        hh2 = hh1;
        hh1 = vif.per_frame_href;
    end

    initial begin
        vif.per_frame_vsync = 1'b0;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_y       = 8'h00;
        for (int c = 0; c < HD; c++) begin
            m_cur[c]   = 8'h00;
            m_hist1[c] = 8'h00;
            m_hist2[c] = 8'h00;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Frame A: pattern pixels, full lines, continuous clken.
        start_frame();
        for (int r = 0; r < 3; r++) send_line(HD, 1'b0, r, 1'b0);

        // Frame B: stale memory masked at frame start; over-long middle line.
        start_frame();
        send_line(HD, 1'b0, 0, 1'b0);
        send_line(HD + 2, 1'b0, 1, 1'b0);
        send_line(HD, 1'b0, 2, 1'b0);

        // Random frames with clken gaps and varying line lengths.
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = $urandom_range(3, 5);
            start_frame();
            for (int l = 0; l < nl; l++) send_line($urandom_range(2, 6), 1'b1, l, 1'b1);
        end

        // Reset in the middle of line 1, then a full pattern frame.
        start_frame();
        send_line(HD, 1'b0, 0, 1'b0);
        drive_pixel(8'h11);
        drive_pixel(8'h12);
        rst = 1'b1;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_y       = 8'h00;
        sb_q.delete();
        model_line_end();
        m_line = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        start_frame();
        for (int r = 0; r < 3; r++) send_line(HD, 1'b0, r, 1'b0);

        // Drain with a bounded wait for the outstanding windows.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        repeat (3) tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d windows still pending, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
